tamagotchi_btn_conditioner: RTL and testbench
=============================================

Name: tamagotchi_btn_conditioner

Overview:
Upstream input stage for the tamagotchi state machine. It takes raw, bouncing board push-buttons and synchronises and debounces each one. For the four care buttons it produces single-cycle press pulses. For the reset and test buttons it produces 0–5 s hold counters plus a one-cycle qualified pulse once the hold reaches 5 s. All outputs connect directly to the tamagotchi FSM's btn_*, count_reset and count_test inputs.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz).
TICK_CYCLES, 50000000, clk cycles per hold-timer second.
HOLD_SECONDS, 5, seconds of hold needed to fire btn_reset / btn_test; must be ≤7.
RAW_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed; 0 = read 1 when pressed.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
raw_salud  input  1  raw button, asynchronous to clk
raw_energia  input  1  raw button
raw_hambre  input  1  raw button
raw_diversion  input  1  raw button
raw_reset  input  1  raw button
raw_test  input  1  raw button
btn_salud  output  1  one-cycle press pulse
btn_energia  output  1  one-cycle press pulse
btn_hambre  output  1  one-cycle press pulse
btn_diversion  output  1  one-cycle press pulse
btn_reset  output  1  one-cycle pulse when the reset hold reaches HOLD_SECONDS
btn_test  output  1  one-cycle pulse when the test hold reaches HOLD_SECONDS
count_reset  output  3  whole seconds raw_reset has been held (0..HOLD_SECONDS)
count_test  output  3  whole seconds raw_test has been held (0..HOLD_SECONDS)

Behaviour:
- Reset: asynchronous, active-low.
  - All outputs reset to 0; synchronisers, debounce counters and tick counters reset to 0.
  - Debounced state resets to "released".
  - Deasserting rst_n while a button is physically held must not produce a pulse until that press has been debounced.
- Input path, per button:
  - 2-flop synchroniser, then polarity normalisation per RAW_ACTIVE_LOW; pressed = 1 after normalisation.
- Debounce, per button:
  - A counter runs while the synchronised level differs from the debounced state, and clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES−1 while still differing, the debounced state flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Care buttons (salud, energia, hambre, diversion):
  - btn_x = 1 for exactly the one cycle after the debounced state goes 0→1. No pulse on release.
  - Latency from a clean raw press to btn_x is DEBOUNCE_CYCLES+3 clk.
  - The four buttons are independent; simultaneous presses give simultaneous pulses.
- Hold buttons (reset, test): per-button state machine IDLE → HOLDING → FIRED.
  - IDLE: count = 0, tick counter = 0. Debounced press → HOLDING.
  - HOLDING: the tick counter increments every cycle.
    - At TICK_CYCLES−1 the tick counter wraps to 0 and count increments.
    - When count becomes HOLD_SECONDS, the pulse fires for one cycle, coincident with the count update, and the state goes to FIRED.
  - FIRED: count stays saturated at HOLD_SECONDS; no further pulses.
  - Debounced release from HOLDING or FIRED → IDLE, with count and tick counter cleared the next cycle.
  - A release before HOLD_SECONDS produces no pulse.
- Reset/test collision:
  - If btn_reset and btn_test would fire in the same cycle, btn_reset fires and btn_test is suppressed.
  - The test machine still goes to FIRED.
- Care buttons are not masked by reset/test holds.

Optional Feature:
BTN_AUTOREPEAT_EN
- Defined: while a care button stays debounced-pressed, a per-button tick counter runs. After the first full TICK_CYCLES, and every TICK_CYCLES after that, btn_x pulses again for one cycle. The counter clears on release.
- Not defined: exactly one pulse per press; no repeat logic is synthesised.

Test Plan (parameters DEBOUNCE_CYCLES=4, TICK_CYCLES=10, HOLD_SECONDS=5, RAW_ACTIVE_LOW=1):
- raw_hambre low for 20 clk, then high → btn_hambre high for exactly 1 cycle, 7 clk after the falling edge; no pulse on release.
- raw_salud low for 2 clk, repeated 5 times with 2 clk high between → btn_salud never asserts.
- raw_reset held low for 60 clk → count_reset steps 0,1,2,3,4,5 every 10 clk; btn_reset pulses once as count reaches 5; count_reset stays 5; release returns it to 0.
- raw_test held for 35 clk then released → count_test reaches 3, then 0; btn_test never asserts.
- raw_reset and raw_test pressed on the same clk and held 60 clk → btn_reset pulses once, btn_test stays 0, both counts read 5.
- rst_n pulsed low mid-hold with count_reset=3 → all outputs 0 immediately; with the button still held, count restarts from 0 after debounce.

Source files
------------

// File: rtl/tamagotchi_btn_conditioner.sv
// Button synchroniser/debouncer, care-press pulses and reset/test hold timers.
// Optional BTN_AUTOREPEAT_EN: care buttons re-pulse every TICK_CYCLES while held.

module tamagotchi_btn_db #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RAW_ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          lvl;

  assign lvl = sync_q[1] ^ (RAW_ACTIVE_LOW != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (lvl == db) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        db    <= ~db;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

module tamagotchi_btn_hold #(
  parameter int TICK_CYCLES  = 50000000,
  parameter int HOLD_SECONDS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       db,
  output logic       fire,
  output logic [2:0] count
);
  localparam int TW = $clog2(TICK_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLDING,
    FIRED
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    cnt_d;
  logic [2:0]    cnt_inc;

  assign cnt_inc = count + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      count   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    cnt_d   = count;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        cnt_d  = '0;
        if (db) state_d = HOLDING;
      end
      HOLDING: begin
        if (!db) begin
          state_d = IDLE;
          tick_d  = '0;
          cnt_d   = '0;
        end else if (tick_q == TW'(TICK_CYCLES - 1)) begin
          tick_d = '0;
          cnt_d  = cnt_inc;
          if (cnt_inc == 3'(HOLD_SECONDS)) begin
            fire    = 1'b1;
            state_d = FIRED;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      FIRED: begin
        if (!db) begin
          state_d = IDLE;
          tick_d  = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end
endmodule

module tamagotchi_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 50000000,
  parameter int HOLD_SECONDS    = 5,
  parameter int RAW_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_salud,
  input  logic       raw_energia,
  input  logic       raw_hambre,
  input  logic       raw_diversion,
  input  logic       raw_reset,
  input  logic       raw_test,
  output logic       btn_salud,
  output logic       btn_energia,
  output logic       btn_hambre,
  output logic       btn_diversion,
  output logic       btn_reset,
  output logic       btn_test,
  output logic [2:0] count_reset,
  output logic [2:0] count_test
);
  logic [5:0] raw;
  logic [5:0] db;
  logic [3:0] db_q;
  logic [3:0] care_q;
  logic [3:0] rep_hit;
  logic       fire_r;
  logic       fire_t;

  assign raw = {raw_test, raw_reset, raw_diversion,
                raw_hambre, raw_energia, raw_salud};

  for (genvar i = 0; i < 6; i++) begin : g_db
    tamagotchi_btn_db #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RAW_ACTIVE_LOW (RAW_ACTIVE_LOW)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[i]),
      .db   (db[i])
    );
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int TW = $clog2(TICK_CYCLES + 1);
  for (genvar i = 0; i < 4; i++) begin : g_rep
    logic [TW-1:0] rep_q;
    assign rep_hit[i] = db[i] & (rep_q == TW'(TICK_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                rep_q <= '0;
      else if (!db[i])                           rep_q <= '0;
      else if (rep_q == TW'(TICK_CYCLES - 1))   rep_q <= '0;
      else                                       rep_q <= rep_q + 1'b1;
    end
  end
`else
  assign rep_hit = 4'b0000;
`endif

  // Pulse lands the cycle after the debounced rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q   <= '0;
      care_q <= '0;
    end else begin
      db_q   <= db[3:0];
      care_q <= (db[3:0] & ~db_q) | rep_hit;
    end
  end

  assign {btn_diversion, btn_hambre,
          btn_energia, btn_salud} = care_q;

  tamagotchi_btn_hold #(
    .TICK_CYCLES (TICK_CYCLES),
    .HOLD_SECONDS(HOLD_SECONDS)
  ) u_hold_reset (
    .clk  (clk),
    .rst_n(rst_n),
    .db   (db[4]),
    .fire (fire_r),
    .count(count_reset)
  );

  tamagotchi_btn_hold #(
    .TICK_CYCLES (TICK_CYCLES),
    .HOLD_SECONDS(HOLD_SECONDS)
  ) u_hold_test (
    .clk  (clk),
    .rst_n(rst_n),
    .db   (db[5]),
    .fire (fire_t),
    .count(count_test)
  );

  // Registered alongside the count so the pulse coincides with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_reset <= 1'b0;
      btn_test  <= 1'b0;
    end else begin
      btn_reset <= fire_r;
      btn_test  <= fire_t & ~fire_r;
    end
  end
endmodule

// File: tb/tb_tamagotchi_btn_conditioner.sv
// Randomised and directed bench for tamagotchi_btn_conditioner.
// Small-parameter build checked against a run-length reference model.

module tb_tamagotchi_btn_conditioner;
  localparam int D = 4;
  localparam int T = 10;
  localparam int H = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic raw_salud = 1'b1;
  logic raw_energia = 1'b1;
  logic raw_hambre = 1'b1;
  logic raw_diversion = 1'b1;
  logic raw_reset = 1'b1;
  logic raw_test = 1'b1;
  logic btn_salud, btn_energia, btn_hambre, btn_diversion;
  logic btn_reset, btn_test;
  logic [2:0] count_reset, count_test;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  tamagotchi_btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES    (T),
    .HOLD_SECONDS   (H),
    .RAW_ACTIVE_LOW (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_salud    (raw_salud),
    .raw_energia  (raw_energia),
    .raw_hambre   (raw_hambre),
    .raw_diversion(raw_diversion),
    .raw_reset    (raw_reset),
    .raw_test     (raw_test),
    .btn_salud    (btn_salud),
    .btn_energia  (btn_energia),
    .btn_hambre   (btn_hambre),
    .btn_diversion(btn_diversion),
    .btn_reset    (btn_reset),
    .btn_test     (btn_test),
    .count_reset  (count_reset),
    .count_test   (count_test)
  );

  // Reference model: a raw sample takes two edges to reach the debouncer;
  // D consecutive samples disagreeing with the accepted level flip it.
  // Hold count = whole seconds since the press was accepted, capped at H.
  logic [5:0] raw_v;
  assign raw_v = {raw_test, raw_reset, raw_diversion,
                  raw_hambre, raw_energia, raw_salud};

  bit s0 [6];
  bit s1 [6];
  bit mdb [6];
  bit mdbp [6];
  int run [6];
  int rise [6];
  bit e_btn [6];
  int e_cnt [6];
  int n;
  int held;
  bit lvl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      for (int b = 0; b < 6; b++) begin
        s0[b] = 0; s1[b] = 0; mdb[b] = 0; mdbp[b] = 0;
        run[b] = 0; rise[b] = 0; e_btn[b] = 0; e_cnt[b] = 0;
      end
    end else begin
      n = n + 1;
      for (int b = 0; b < 6; b++) begin
        lvl = !s1[b];
        s1[b] = s0[b];
        s0[b] = raw_v[b];
        if (b < 4) begin
          e_btn[b] = mdb[b] && !mdbp[b];
        end else begin
          held = n - rise[b] - 1;
          e_cnt[b] = mdb[b] ? ((held / T > H) ? H : held / T) : 0;
          e_btn[b] = mdb[b] && (held == H * T);
        end
        mdbp[b] = mdb[b];
        if (lvl != mdb[b]) begin
          run[b] = run[b] + 1;
          if (run[b] == D) begin
            mdb[b] = !mdb[b];
            run[b] = 0;
            if (mdb[b]) rise[b] = n;
          end
        end else begin
          run[b] = 0;
        end
      end
      if (e_btn[4]) e_btn[5] = 0;
    end
  end

  function automatic logic [11:0] obs();
    return {btn_salud, btn_energia, btn_hambre, btn_diversion,
            btn_reset, btn_test, count_reset, count_test};
  endfunction

  function automatic logic [11:0] expv();
    return {e_btn[0], e_btn[1], e_btn[2], e_btn[3],
            e_btn[4], e_btn[5], 3'(e_cnt[4]), 3'(e_cnt[5])};
  endfunction

  task automatic release_all();
    raw_salud = 1; raw_energia = 1; raw_hambre = 1;
    raw_diversion = 1; raw_reset = 1; raw_test = 1;
  endtask

  task automatic settle();
    release_all();
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL settle cyc=%0d got=%h want=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    release_all();
    repeat (3) @(negedge clk);
    n_chk++;
    if (obs() !== 12'h000) begin
      n_err++;
      $display("FAIL reset_state got=%h want=000", obs());
    end
    rst_n = 1;
    settle();
  endtask

  task automatic test_care_press();
    int first = -1;
    int pulses = 0;
    raw_hambre = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL care_model cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      if (btn_hambre) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (i == 20) raw_hambre = 1;
    end
    n_chk++;
    if (first !== 7) begin
      n_err++;
      $display("FAIL care_latency got=%0d want=7", first);
    end
    n_chk++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL care_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    raw_salud = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL glitch_model cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      if (btn_salud) pulses++;
      raw_salud = (i < 20 && (i % 4) < 2) ? 1'b0 : 1'b1;
    end
    n_chk++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL glitch_pulses got=%0d want=0", pulses);
    end
  endtask

  task automatic test_hold_full();
    int pulses = 0;
    int at_pulse = -1;
    logic [2:0] c27, c59;
    raw_reset = 0;
    for (int i = 1; i <= 75; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL hold_model cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      if (btn_reset) begin
        pulses++;
        at_pulse = i;
      end
      if (i == 27) c27 = count_reset;
      if (i == 59) c59 = count_reset;
      if (i == 60) raw_reset = 1;
    end
    n_chk++;
    if (pulses !== 1 || at_pulse !== 57) begin
      n_err++;
      $display("FAIL hold_pulse got=%0d@%0d want=1@57", pulses, at_pulse);
    end
    n_chk++;
    if (c27 !== 3'd2) begin
      n_err++;
      $display("FAIL hold_step got=%0d want=2", c27);
    end
    n_chk++;
    if (c59 !== 3'd5) begin
      n_err++;
      $display("FAIL hold_sat got=%0d want=5", c59);
    end
    n_chk++;
    if (count_reset !== 3'd0) begin
      n_err++;
      $display("FAIL hold_clear got=%0d want=0", count_reset);
    end
  endtask

  task automatic test_hold_short();
    int pulses = 0;
    int mx = 0;
    raw_test = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL short_model cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      if (btn_test) pulses++;
      if (int'(count_test) > mx) mx = int'(count_test);
      if (i == 35) raw_test = 1;
    end
    n_chk++;
    if (mx !== 3 || pulses !== 0 || count_test !== 3'd0) begin
      n_err++;
      $display("FAIL short_hold got=max%0d/p%0d/c%0d want=max3/p0/c0",
               mx, pulses, count_test);
    end
  endtask

  task automatic test_collision();
    int pr = 0;
    int pt = 0;
    logic [2:0] cr, ct;
    raw_reset = 0;
    raw_test = 0;
    for (int i = 1; i <= 75; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL coll_model cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      if (btn_reset) pr++;
      if (btn_test) pt++;
      if (i == 59) begin
        cr = count_reset;
        ct = count_test;
      end
      if (i == 60) release_all();
    end
    n_chk++;
    if (pr !== 1 || pt !== 0) begin
      n_err++;
      $display("FAIL coll_pulses got=r%0d/t%0d want=r1/t0", pr, pt);
    end
    n_chk++;
    if (cr !== 3'd5 || ct !== 3'd5) begin
      n_err++;
      $display("FAIL coll_counts got=%0d/%0d want=5/5", cr, ct);
    end
  endtask

  task automatic test_reset_midhold();
    bit hit = 0;
    int pulses = 0;
    raw_reset = 0;
    for (int i = 1; i <= 100 && !hit; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL mid_model cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      if (count_reset == 3'd3) hit = 1;
    end
    n_chk++;
    if (!hit) begin
      n_err++;
      $display("FAIL mid_wait got=timeout want=count3");
    end
    rst_n = 0;
    #1;
    n_chk++;
    if (obs() !== 12'h000) begin
      n_err++;
      $display("FAIL mid_async got=%h want=000", obs());
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL mid_after cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      if (btn_reset) pulses++;
      if (i == 1 && count_reset !== 3'd0) begin
        n_err++;
        $display("FAIL mid_restart got=%0d want=0", count_reset);
      end
    end
    n_chk++;
    if (count_reset == 3'd0 || pulses !== 0) begin
      n_err++;
      $display("FAIL mid_recount got=c%0d/p%0d want=c>0/p0",
               count_reset, pulses);
    end
    release_all();
  endtask

  task automatic test_random();
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL rand_model cyc=%0d got=%h want=%h", i, obs(), expv());
      end
      if ($urandom_range(5) == 0) raw_salud = ~raw_salud;
      if ($urandom_range(5) == 0) raw_energia = ~raw_energia;
      if ($urandom_range(7) == 0) raw_hambre = ~raw_hambre;
      if ($urandom_range(9) == 0) raw_diversion = ~raw_diversion;
      if ($urandom_range(49) == 0) raw_reset = ~raw_reset;
      if ($urandom_range(39) == 0) raw_test = ~raw_test;
    end
  endtask

  initial begin
    test_reset();
    test_care_press();
    settle();
    test_glitch();
    settle();
    test_hold_full();
    settle();
    test_hold_short();
    settle();
    test_collision();
    settle();
    test_reset_midhold();
    settle();
    test_random();
    settle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
